// File: rtl/dram_responder.sv
// Handshaked word-array target for the processor data-memory port.
// Fixed wait-state insertion, one-cycle ready pulse, range error flag.
module dram_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr_in,
  input  logic [15:0] data_in,
  input  logic [1:0]  mem_write,
  output logic [15:0] data_out,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [15:0] cap_addr, cap_data;
  logic        cap_wr;
  logic        err_q;

  logic        req, take, acc;
  logic        acc_wr, in_range;
  logic [15:0] acc_addr, acc_data;
  logic [ADDR_W-1:0] idx;

  logic [15:0] mem [DEPTH];

  assign req = (mem_write == 2'b01) || (mem_write == 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    take     = 1'b0;
    acc      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          take = 1'b1;
          if (WS == 4'd0) begin
            acc      = 1'b1;
            state_nx = RESP;
          end else begin
            cnt_nx   = WS;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          acc      = 1'b1;
          cnt_nx   = 4'd0;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Zero-wait accesses use the live bus; otherwise the captured copy.
  assign acc_addr = (state == IDLE) ? addr_in : cap_addr;
  assign acc_data = (state == IDLE) ? data_in : cap_data;
  assign acc_wr   = (state == IDLE) ? (mem_write == 2'b10) : cap_wr;
  assign in_range = (acc_addr >> ADDR_W) == 16'd0;
  assign idx      = acc_addr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr <= 16'h0000;
      cap_data <= 16'h0000;
      cap_wr   <= 1'b0;
      err_q    <= 1'b0;
      data_out <= 16'h0000;
    end else begin
      if (take) begin
        cap_addr <= addr_in;
        cap_data <= data_in;
        cap_wr   <= (mem_write == 2'b10);
      end
      if (acc) begin
        err_q <= !in_range;
        if (!acc_wr)
          data_out <= in_range ? mem[idx] : 16'h0000;
      end
    end
  end

  // Array is never cleared; a held reset must still block writes.
  always_ff @(posedge clk) begin
    if (rst_n && acc && acc_wr && in_range)
      mem[idx] <= acc_data;
  end

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);
  assign err   = (state == RESP) && err_q;

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder at 0, 1 and 3 wait states.
// Instance n of the arrays drives the DUT with WAIT_STATES = ws_of(n).
module tb_dram_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a  [3];
  logic [15:0] d  [3];
  logic [1:0]  mw [3];
  logic [15:0] dout [3];
  logic        rdy [3];
  logic        bsy [3];
  logic        er  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dram_responder #(.ADDR_W(9), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .addr_in(a[0]), .data_in(d[0]),
    .mem_write(mw[0]), .data_out(dout[0]), .ready(rdy[0]),
    .busy(bsy[0]), .err(er[0]));

  dram_responder #(.ADDR_W(9), .WAIT_STATES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .addr_in(a[1]), .data_in(d[1]),
    .mem_write(mw[1]), .data_out(dout[1]), .ready(rdy[1]),
    .busy(bsy[1]), .err(er[1]));

  dram_responder #(.ADDR_W(9), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .addr_in(a[2]), .data_in(d[2]),
    .mem_write(mw[2]), .data_out(dout[2]), .ready(rdy[2]),
    .busy(bsy[2]), .err(er[2]));

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, return cycles-to-ready, busy cycles, data, err.
  task automatic xfer(input int i, input logic [1:0] op,
                      input logic [15:0] ad, input logic [15:0] dt,
                      output int lat, output int bcnt,
                      output logic [15:0] rd, output logic e);
    lat  = 0;
    bcnt = 0;
    rd   = 16'hxxxx;
    e    = 1'bx;
    @(negedge clk);
    a[i] = ad; d[i] = dt; mw[i] = op;
    @(posedge clk);
    #1 mw[i] = 2'b00;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bsy[i]) bcnt++;
      if (rdy[i]) begin
        lat = n;
        rd  = dout[i];
        e   = er[i];
        break;
      end
    end
    @(negedge clk);
    chk("ready_one_cycle", {31'd0, rdy[i]}, 32'd0);
    chk("busy_low_after", {31'd0, bsy[i]}, 32'd0);
  endtask

  int          lat, bc, idle_hits;
  logic [15:0] rd;
  logic        e;

  initial begin
    for (int i = 0; i < 3; i++) begin
      a[i] = 16'h0; d[i] = 16'h0; mw[i] = 2'b00;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // Asynchronous reset with a request in flight.
    @(negedge clk);
    a[1] = 16'h0001; mw[1] = 2'b01;
    @(posedge clk);
    #1 mw[1] = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, bsy[1]}, 32'd0);
    chk("rst_ready", {31'd0, rdy[1]}, 32'd0);
    chk("rst_err", {31'd0, er[1]}, 32'd0);
    chk("rst_dout", {16'd0, dout[1]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WAIT_STATES = 1 write then read.
    xfer(1, 2'b10, 16'h0005, 16'hBEEF, lat, bc, rd, e);
    chk("w1_lat", lat, 2);
    chk("w1_busy", bc, 2);
    chk("w1_err", {31'd0, e}, 32'd0);
    chk("w1_dout_untouched", {16'd0, rd}, 32'd0);
    xfer(1, 2'b01, 16'h0005, 16'h0000, lat, bc, rd, e);
    chk("r1_lat", lat, 2);
    chk("r1_data", {16'd0, rd}, 32'h0000BEEF);
    xfer(1, 2'b10, 16'h0006, 16'hCAFE, lat, bc, rd, e);
    chk("dout_hold", {16'd0, dout[1]}, 32'h0000BEEF);

    // Wait-state sweep.
    for (int i = 0; i < 3; i += 2) begin
      xfer(i, 2'b10, 16'h0003, 16'h1357 + 16'(i), lat, bc, rd, e);
      chk("sw_wlat", lat, ws_of(i) + 1);
      xfer(i, 2'b01, 16'h0003, 16'h0000, lat, bc, rd, e);
      chk("sw_rlat", lat, ws_of(i) + 1);
      chk("sw_rbusy", bc, ws_of(i) + 1);
      chk("sw_rdata", {16'd0, rd}, {16'd0, 16'h1357 + 16'(i)});
    end

    // Out of range on WAIT_STATES = 1.
    xfer(1, 2'b10, 16'h0000, 16'h5555, lat, bc, rd, e);
    xfer(1, 2'b10, 16'h0200, 16'h1234, lat, bc, rd, e);
    chk("oor_w_err", {31'd0, e}, 32'd1);
    xfer(1, 2'b01, 16'h0200, 16'h0000, lat, bc, rd, e);
    chk("oor_r_err", {31'd0, e}, 32'd1);
    chk("oor_r_data", {16'd0, rd}, 32'd0);
    xfer(1, 2'b01, 16'h0000, 16'h0000, lat, bc, rd, e);
    chk("oor_a0", {16'd0, rd}, 32'h00005555);
    chk("oor_a0_err", {31'd0, e}, 32'd0);

    // Reserved code held for five cycles.
    idle_hits = 0;
    @(negedge clk);
    mw[1] = 2'b11; a[1] = 16'h0005;
    repeat (5) begin
      @(negedge clk);
      if (bsy[1] || rdy[1] || er[1]) idle_hits++;
    end
    mw[1] = 2'b00;
    chk("reserved_idle", idle_hits, 0);

    // Second request during WAIT/RESP, removed before IDLE.
    xfer(2, 2'b10, 16'h0009, 16'h2222, lat, bc, rd, e);
    @(negedge clk);
    a[2] = 16'h0003; d[2] = 16'h4444; mw[2] = 2'b10;
    @(posedge clk);
    #1 a[2] = 16'h0009; d[2] = 16'h3333;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rdy[2]) begin lat = n; break; end
    end
    chk("ovl_lat", lat, 4);
    @(posedge clk);
    #1 mw[2] = 2'b00;
    @(negedge clk);
    chk("ovl_busy", {31'd0, bsy[2]}, 32'd0);
    xfer(2, 2'b01, 16'h0009, 16'h0000, lat, bc, rd, e);
    chk("ovl_a9", {16'd0, rd}, 32'h00002222);
    xfer(2, 2'b01, 16'h0003, 16'h0000, lat, bc, rd, e);
    chk("ovl_a3", {16'd0, rd}, 32'h00004444);

    // Reset during WAIT drops the write.
    xfer(2, 2'b10, 16'h0007, 16'h1111, lat, bc, rd, e);
    @(negedge clk);
    a[2] = 16'h0007; d[2] = 16'hAAAA; mw[2] = 2'b10;
    @(posedge clk);
    #1 mw[2] = 2'b00;
    @(negedge clk);
    chk("mid_busy", {31'd0, bsy[2]}, 32'd1);
    rst_n = 1'b0;
    #1 chk("mid_rst_busy", {31'd0, bsy[2]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy[2] || bsy[2]) idle_hits++;
    end
    chk("mid_no_ready", idle_hits, 0);
    xfer(2, 2'b01, 16'h0007, 16'h0000, lat, bc, rd, e);
    chk("mid_a7", {16'd0, rd}, 32'h00001111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_responder.md
# dram_responder

Memory-side responder for the processor's data-memory port. It accepts one read or write request at a time on the processor's address/data/mem_write bus, inserts a programmable number of wait states, and performs the access on an internal word array. It then signals completion with a one-cycle ready pulse. It sits between the processor's memory outputs and the data-bus input in the top layer, replacing the bare memory instance with a handshaked target.

## Interface
- ADDR_W, 9, word-address width of the internal array; DEPTH = 2^ADDR_W words of 16 bits
- WAIT_STATES, 1, extra cycles between request acceptance and the access edge; legal range 0-15
- clk  input  1  single system clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- addr_in  input  16  word address from processor
- data_in  input  16  write data from processor
- mem_write  input  2  request code: 2'b00 idle, 2'b01 read, 2'b10 write, 2'b11 reserved
- data_out  output  16  read data to processor data bus
- ready  output  1  one-cycle completion pulse
- busy  output  1  high whenever a request is in progress (state != IDLE)
- err  output  1  one-cycle pulse with ready when the completed request was out of range

## Operation
- Decided: one clock; reset is asynchronous and active-low (clk, rst_n).
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE
  - Requests are sampled only in IDLE.
  - mem_write of 01 or 10 captures addr_in, data_in and the opcode into internal registers.
  - If WAIT_STATES = 0, the access is performed on the same edge and the FSM goes to RESP. Otherwise the counter loads WAIT_STATES and the FSM goes to WAIT.
  - mem_write of 00 or 11 is ignored. Code 11 is never accepted and never raises err.
- WAIT
  - The counter decrements each edge.
  - On the edge where the counter is 1, the access is performed and the FSM goes to RESP.
  - Bus inputs are ignored, because the captured copies are used.
- RESP
  - ready = 1 for exactly this cycle, then the FSM returns to IDLE unconditionally.
  - A request present during RESP is not accepted. It must still be present in IDLE to be taken.
- Access
  - A request is in range when addr_in[15:ADDR_W] == 0.
  - Write: array[addr] <= data.
  - Read: data_out <= array[addr].
  - Out of range: no array write; a read loads data_out with 16'h0000; err is pulsed during RESP.
- data_out holds its value until the next completed read. Writes do not disturb it.
- The array is not reset, so its contents are undefined until written. Reset does not clear contents already written.
- Reset mid-operation: the FSM is forced to IDLE and the counter to 0. An in-flight request is dropped with no array write and no ready.

## Timing
- Reset values: data_out = 16'h0000, ready = 0, busy = 0, err = 0, state = IDLE, counter = 0.
- With the request sampled on edge k:
  - The access is performed on edge k + WAIT_STATES.
  - ready, and err if applicable, are high for the cycle after edge k + WAIT_STATES.
  - data_out is valid from the start of that ready cycle.
- busy rises after edge k and falls after the edge that ends RESP.
- Throughput is one request per WAIT_STATES + 2 cycles if the processor holds the next request on the bus.
- ready, busy and err are Moore outputs, registered from state with no combinational path from inputs.
- Read-after-write to the same address returns the newly written data. The two accesses are strictly sequential, so no bypass is needed.

## Test plan
- Reset values: assert rst_n = 0 mid-cycle -> all outputs 0 immediately, asynchronously.
- Write then read, WAIT_STATES = 1:
  - write 16'hBEEF to address 9'h005 -> ready after edge k+1, busy high for 2 cycles.
  - read address 5 -> data_out = 16'hBEEF together with ready.
- Wait-state sweep with WAIT_STATES = 0 and 3: the read is sampled on edge k -> ready is high in the cycle after edge k+0 and edge k+3 respectively, and is never longer than 1 cycle.
- Out of range: write 16'h1234 to addr 16'h0200, then read 16'h0200 -> err pulses with ready on both; the read returns 16'h0000; array[0] is unchanged.
- Reserved and busy:
  - mem_write = 11 held for 5 cycles -> busy stays 0, no ready.
  - a second request presented during WAIT/RESP and removed before IDLE -> not executed.
- Reset mid-WAIT (WAIT_STATES = 3): pull rst_n low 1 cycle after a write of 16'hAAAA to addr 7 -> no ready; a later read of addr 7 returns the prior contents, not 16'hAAAA.
